word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer_pkg.sv | 13 +
 rtl/word_serializer_lane_mux.sv | 14 +
 rtl/word_serializer.sv | 118 +++++++++++
 tb/tb_word_serializer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/word_serializer_pkg.sv
// Shared types and default geometry for the word serializer.
// Holds the FSM state encoding and the default word/lane widths.
package word_serializer_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_LANE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage : word_serializer_pkg

// File: rtl/word_serializer_lane_mux.sv
// Combinational lane selector: picks lane idx_i out of word_i.
// Used by the serializer to drive out_data from the captured word.
module lane_mux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANE_W = 8
) (
  input  logic [DATA_W-1:0]                  word_i,
  input  logic [$clog2(DATA_W/LANE_W)-1:0]   idx_i,
  output logic [LANE_W-1:0]                  lane_o
);

  assign lane_o = word_i[idx_i*LANE_W +: LANE_W];

endmodule : lane_mux

// File: rtl/word_serializer.sv
// Splits a captured word into LANE_W-bit lanes, emitted one per handshake,
// lanes 0..len in either msb-first (len down to 0) or lsb-first order.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LANE_W = DEF_LANE_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_W-1:0]                   in_data,
  input  logic [$clog2(DATA_W/LANE_W)-1:0]    in_len,
  input  logic                                in_msb_first,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LANE_W-1:0]                   out_data,
  output logic [$clog2(DATA_W/LANE_W)-1:0]    out_idx,
  output logic                                out_last,
  output logic                                busy
);

  localparam int unsigned LANES = DATA_W / LANE_W;
  localparam int unsigned LEN_W = $clog2(LANES);
  localparam logic [LEN_W-1:0] MAX_IDX = LEN_W'(LANES - 1);

  if (((DATA_W % LANE_W) != 0) || (LANES < 2)) begin : g_bad_params
    $error("word_serializer: DATA_W must be a multiple of LANE_W with at least 2 lanes");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [LEN_W-1:0]  len_q,   len_d;
  logic [LEN_W-1:0]  idx_q,   idx_d;
  logic              msb_q,   msb_d;
  logic              last_lane;

  // The final lane depends on direction: 0 when counting down, len when counting up.
  assign last_lane = msb_q ? (idx_q == '0) : (idx_q == len_q);

  // NOTE: every output and next-state signal gets a default before the case so no
  // path through this block leaves a value unassigned (which would infer a latch).
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    len_d     = len_q;
    idx_d     = idx_q;
    msb_d     = msb_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Clamp keeps the index inside 0..LANES-1 when LANES is not a power of two.
          len_d   = (in_len > MAX_IDX) ? MAX_IDX : in_len;
          data_d  = in_data;
          msb_d   = in_msb_first;
          idx_d   = in_msb_first ? len_d : '0;
          state_d = SEND;
        end
      end

      SEND: begin
        out_valid = 1'b1;
        out_last  = last_lane;
        busy      = 1'b1;
        if (out_ready) begin
          if (last_lane) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = msb_q ? (idx_q - 1'b1) : (idx_q + 1'b1);
          end
        end
      end

      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: the data register is reset too, so out_data reads 0 while rst_n is low;
  // state is only ever updated with non-blocking assignments here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      msb_q   <= msb_d;
    end
  end

  assign out_idx = idx_q;

  lane_mux #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_lane_mux (
    .word_i (data_q),
    .idx_i  (idx_q),
    .lane_o (out_data)
  );

endmodule : word_serializer

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: hand-computed lanes, back-pressure and resets.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_word_serializer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned LEN_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [LEN_W-1:0]  in_len;
  logic              in_msb_first;
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_data;
  logic [LEN_W-1:0]  out_idx;
  logic              out_last;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  word_serializer #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_len       (in_len),
    .in_msb_first (in_msb_first),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_idx      (out_idx),
    .out_last     (out_last),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".in_ready"},  32'(in_ready),  32'd1);
    check({tag, ".out_last"},  32'(out_last),  32'd0);
  endtask

  // Presents one word for a single cycle, starting and ending on a falling edge.
  task automatic accept(input logic [31:0] data, input logic [1:0] len, input logic msb);
    in_data      = data;
    in_len       = len;
    in_msb_first = msb;
    in_valid     = 1'b1;
    check("accept.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid     = 1'b0;
    in_data      = 32'hDEAD_BEEF;
    in_len       = 2'd0;
    in_msb_first = ~msb;
  endtask

  // Checks the lane currently presented, then lets one clock edge pass.
  task automatic expect_lane(input string tag, input logic [7:0] data,
                             input logic [1:0] idx, input logic last);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".busy"},      32'(busy),      32'd1);
    check({tag, ".out_data"},  32'(out_data),  32'(data));
    check({tag, ".out_idx"},   32'(out_idx),   32'(idx));
    check({tag, ".out_last"},  32'(out_last),  32'(last));
    @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b1;
    in_data      = 32'h1111_2222;
    in_len       = 2'd3;
    in_msb_first = 1'b1;
    out_ready    = 1'b1;

    // Reset held across edges with in_valid high: nothing may be captured.
    @(negedge clk);
    @(negedge clk);
    check_idle("rst");
    check("rst.out_idx",  32'(out_idx),  32'd0);
    check("rst.out_data", 32'(out_data), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

    // Full word, msb-first.
    accept(32'h1234_5678, 2'd3, 1'b1);
    expect_lane("msb0", 8'h12, 2'd3, 1'b0);
    expect_lane("msb1", 8'h34, 2'd2, 1'b0);
    expect_lane("msb2", 8'h56, 2'd1, 1'b0);
    expect_lane("msb3", 8'h78, 2'd0, 1'b1);
    check_idle("msb_done");

    // Same word, lsb-first; ready again on the following cycle.
    accept(32'h1234_5678, 2'd3, 1'b0);
    expect_lane("lsb0", 8'h78, 2'd0, 1'b0);
    expect_lane("lsb1", 8'h56, 2'd1, 1'b0);
    expect_lane("lsb2", 8'h34, 2'd2, 1'b0);
    expect_lane("lsb3", 8'h12, 2'd3, 1'b1);
    check_idle("lsb_done");

    // Short words: two lanes, then single lanes in both directions.
    accept(32'hAABB_CCDD, 2'd1, 1'b1);
    expect_lane("len1_0", 8'hCC, 2'd1, 1'b0);
    expect_lane("len1_1", 8'hDD, 2'd0, 1'b1);
    accept(32'hAABB_CCDD, 2'd0, 1'b1);
    expect_lane("len0_msb", 8'hDD, 2'd0, 1'b1);
    accept(32'hAABB_CCDD, 2'd0, 1'b0);
    expect_lane("len0_lsb", 8'hDD, 2'd0, 1'b1);
    check_idle("len0_done");

    // Back-pressure after the second lane while the source keeps pushing.
    accept(32'h1234_5678, 2'd3, 1'b1);
    expect_lane("bp0", 8'h12, 2'd3, 1'b0);
    expect_lane("bp1", 8'h34, 2'd2, 1'b0);
    out_ready = 1'b0;
    in_data   = 32'hFFFF_FFFF;
    in_len    = 2'd0;
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid;
      in_data  = in_data ^ 32'h0F0F_0F0F;
      check("bp_hold.out_data", 32'(out_data), 32'h56);
      check("bp_hold.out_idx",  32'(out_idx),  32'd1);
      check("bp_hold.out_last", 32'(out_last), 32'd0);
      check("bp_hold.in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    expect_lane("bp2", 8'h56, 2'd1, 1'b0);
    expect_lane("bp3", 8'h78, 2'd0, 1'b1);
    check_idle("bp_done");
    @(negedge clk);
    check_idle("bp_no_capture");

    // Reset mid-word, asserted between edges, then a fresh single-lane word.
    accept(32'h1234_5678, 2'd3, 1'b0);
    expect_lane("mid0", 8'h78, 2'd0, 1'b0);
    expect_lane("mid1", 8'h56, 2'd1, 1'b0);
    check("mid_pre.out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("mid_rst");
    check("mid_rst.out_idx",  32'(out_idx),  32'd0);
    check("mid_rst.out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    accept(32'h0000_A5A5, 2'd0, 1'b1);
    expect_lane("after_rst", 8'hA5, 2'd0, 1'b1);
    check_idle("after_rst_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_word_serializer
